// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: attract, countdown, play and game-over phases.
// Define MOLE_SPEEDUP_EN to shorten the round period after every mole tick.
module mole_game_ctrl #(
  parameter int unsigned INIT_PERIOD     = 100000000,
  parameter int unsigned MIN_PERIOD      = 25000000,
  parameter int unsigned PERIOD_STEP     = 2500000,
  parameter int unsigned ROUNDS          = 30,
  parameter int unsigned IDLE_PERIOD     = 5000000,
  parameter int unsigned CD_PERIOD       = 100000000,
  parameter int unsigned GAMEOVER_CYCLES = 500000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic [23:0] score_in,
  output logic        game_rst,
  output logic        mole_tick,
  output logic [27:0] round_count,
  output logic [3:0]  idle_step,
  output logic [1:0]  cd_digit,
  output logic [7:0]  round_num,
  output logic [1:0]  state,
  output logic [23:0] final_score,
  output logic [23:0] high_score
);

  typedef enum logic [1:0] {
    ATTRACT   = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    GAMEOVER  = 2'd3
  } phase_t;

`ifdef MOLE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam logic [27:0] P_INIT    = 28'(INIT_PERIOD);
  localparam logic [27:0] P_MIN     = 28'(MIN_PERIOD);
  localparam logic [27:0] P_STEP    = 28'(PERIOD_STEP);
  localparam logic [7:0]  N_RND     = 8'(ROUNDS);
  localparam logic [31:0] IDLE_LAST = 32'(IDLE_PERIOD - 1);
  localparam logic [31:0] CD_LAST   = 32'(CD_PERIOD - 1);
  localparam logic [31:0] GO_LAST   = 32'(GAMEOVER_CYCLES - 1);

  phase_t      cur;
  phase_t      nxt;
  logic [31:0] tmr;
  logic [31:0] tmr_nx;
  logic [27:0] period;
  logic [27:0] period_nx;
  logic [27:0] shrunk;
  logic [27:0] rc_nx;
  logic [3:0]  idle_nx;
  logic [1:0]  cd_nx;
  logic [7:0]  rn_nx;
  logic [23:0] fs_nx;
  logic [23:0] hs_nx;
  logic        tick_nx;
  logic        grst_nx;
  logic        first;
  logic        first_nx;
  logic        start_q;
  logic        rise;

  assign rise  = start_btn & ~start_q;
  assign state = cur;

  // Saturating period decrement; without speedup the period never moves.
  always_comb begin
    shrunk = period;
    if (SPEEDUP) begin
      if (period >= P_MIN + P_STEP)
        shrunk = period - P_STEP;
      else
        shrunk = P_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= ATTRACT;
      tmr         <= '0;
      period      <= P_INIT;
      round_count <= '0;
      idle_step   <= '0;
      cd_digit    <= '0;
      round_num   <= '0;
      mole_tick   <= 1'b0;
      game_rst    <= 1'b1;
      final_score <= '0;
      high_score  <= '0;
      first       <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      cur         <= nxt;
      tmr         <= tmr_nx;
      period      <= period_nx;
      round_count <= rc_nx;
      idle_step   <= idle_nx;
      cd_digit    <= cd_nx;
      round_num   <= rn_nx;
      mole_tick   <= tick_nx;
      game_rst    <= grst_nx;
      final_score <= fs_nx;
      high_score  <= hs_nx;
      first       <= first_nx;
      start_q     <= start_btn;
    end
  end

  always_comb begin
    nxt       = cur;
    tmr_nx    = tmr;
    period_nx = period;
    rc_nx     = round_count;
    idle_nx   = idle_step;
    cd_nx     = cd_digit;
    rn_nx     = round_num;
    fs_nx     = final_score;
    hs_nx     = high_score;
    tick_nx   = 1'b0;
    first_nx  = 1'b0;
    unique case (cur)
      ATTRACT: begin
        if (rise) begin
          nxt    = COUNTDOWN;
          cd_nx  = 2'd3;
          tmr_nx = '0;
        end else if (tmr == IDLE_LAST) begin
          tmr_nx  = '0;
          idle_nx = (idle_step == 4'd9) ? 4'd0 : idle_step + 4'd1;
        end else begin
          tmr_nx = tmr + 32'd1;
        end
      end
      COUNTDOWN: begin
        if (tmr == CD_LAST) begin
          tmr_nx = '0;
          if (cd_digit == 2'd1) begin
            nxt       = PLAY;
            cd_nx     = 2'd0;
            rc_nx     = '0;
            rn_nx     = '0;
            period_nx = P_INIT;
          end else begin
            cd_nx = cd_digit - 2'd1;
          end
        end else begin
          tmr_nx = tmr + 32'd1;
        end
      end
      PLAY: begin
        if (round_count == period - 28'd1) begin
          tick_nx   = 1'b1;
          rc_nx     = '0;
          rn_nx     = round_num + 8'd1;
          period_nx = shrunk;
          if (round_num + 8'd1 == N_RND) begin
            nxt      = GAMEOVER;
            tmr_nx   = '0;
            first_nx = 1'b1;
          end
        end else begin
          rc_nx = round_count + 28'd1;
        end
      end
      GAMEOVER: begin
        if (first) begin
          fs_nx = score_in;
          if (score_in > high_score)
            hs_nx = score_in;
        end
        // A restart press beats the display timeout.
        if (!first && rise) begin
          nxt    = COUNTDOWN;
          cd_nx  = 2'd3;
          tmr_nx = '0;
        end else if (tmr == GO_LAST) begin
          nxt     = ATTRACT;
          idle_nx = '0;
          tmr_nx  = '0;
        end else begin
          tmr_nx = tmr + 32'd1;
        end
      end
    endcase
    grst_nx = ~((cur == PLAY) | (nxt == PLAY));
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: phase/time-offset model plus directed scenarios.
// Honours MOLE_SPEEDUP_EN the same way the design does.
module tb_mole_game_ctrl;

  localparam int IP  = 20;
  localparam int MP  = 8;
  localparam int PS  = 4;
  localparam int NR  = 5;
  localparam int IDP = 3;
  localparam int CDP = 10;
  localparam int GOC = 50;

`ifdef MOLE_SPEEDUP_EN
  localparam bit SPEED = 1'b1;
`else
  localparam bit SPEED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn = 1'b0;
  logic [23:0] score_in = '0;
  logic        game_rst;
  logic        mole_tick;
  logic [27:0] round_count;
  logic [3:0]  idle_step;
  logic [1:0]  cd_digit;
  logic [7:0]  round_num;
  logic [1:0]  state;
  logic [23:0] final_score;
  logic [23:0] high_score;

  mole_game_ctrl #(
    .INIT_PERIOD(IP), .MIN_PERIOD(MP), .PERIOD_STEP(PS), .ROUNDS(NR),
    .IDLE_PERIOD(IDP), .CD_PERIOD(CDP), .GAMEOVER_CYCLES(GOC)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .score_in(score_in),
    .game_rst(game_rst), .mole_tick(mole_tick),
    .round_count(round_count), .idle_step(idle_step),
    .cd_digit(cd_digit), .round_num(round_num), .state(state),
    .final_score(final_score), .high_score(high_score)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Length of round k of a game.
  function automatic int per_of(input int k);
    int p;
    p = IP - k * PS;
    if (!SPEED) return IP;
    return (p < MP) ? MP : p;
  endfunction

  function automatic int play_len();
    int s;
    s = 0;
    for (int k = 0; k < NR; k++) s += per_of(k);
    return s;
  endfunction

  // Map cycles-since-play-start to (rounds done, offset in round).
  function automatic void play_pos(input int t, output int r, output int off);
    int s;
    s = 0;
    r = 0;
    while (r < NR && t >= s + per_of(r)) begin
      s += per_of(r);
      r++;
    end
    off = t - s;
  endfunction

  // Model: current phase and cycles elapsed since entering it.
  int          m_phase = 0;
  int          m_t = 0;
  int          m_idle = 0;
  int          m_rn = 0;
  bit          m_prev = 1'b0;
  bit          m_rise;
  logic [23:0] m_fs = '0;
  logic [23:0] m_hs = '0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_t = 0; m_idle = 0; m_rn = 0;
      m_prev = 1'b0; m_fs = '0; m_hs = '0;
    end else begin
      m_rise = start_btn && !m_prev;
      m_prev = start_btn;
      case (m_phase)
        0: begin
          if (m_rise) begin
            m_idle = (m_t / IDP) % 10;
            m_phase = 1; m_t = 0;
          end else m_t++;
        end
        1: begin
          m_t++;
          if (m_t == 3 * CDP) begin m_phase = 2; m_t = 0; end
        end
        2: begin
          m_t++;
          if (m_t == play_len()) begin
            m_phase = 3; m_t = 0; m_rn = NR;
          end
        end
        default: begin
          if (m_t == 0) begin
            m_fs = score_in;
            if (score_in > m_hs) m_hs = score_in;
          end
          if (m_t >= 1 && m_rise) begin
            m_phase = 1; m_t = 0;
          end else begin
            m_t++;
            if (m_t == GOC) begin m_phase = 0; m_t = 0; end
          end
        end
      endcase
    end
  end

  int e_r, e_off;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (m_phase == 2) play_pos(m_t, e_r, e_off);
      else begin e_r = m_rn; e_off = 0; end
      chk("state", 32'(state), 32'(m_phase));
      chk("game_rst", 32'(game_rst),
          32'(!(m_phase == 2 || (m_phase == 3 && m_t == 0))));
      chk("mole_tick", 32'(mole_tick),
          32'((m_phase == 2 && m_t > 0 && e_off == 0) ||
              (m_phase == 3 && m_t == 0)));
      chk("round_count", 32'(round_count), 32'((m_phase == 2) ? e_off : 0));
      chk("round_num", 32'(round_num), 32'(e_r));
      chk("idle_step", 32'(idle_step),
          32'((m_phase == 0) ? (m_t / IDP) % 10 : m_idle));
      chk("cd_digit", 32'(cd_digit),
          32'((m_phase == 1) ? 3 - m_t / CDP : 0));
      chk("final_score", 32'(final_score), 32'(m_fs));
      chk("high_score", 32'(high_score), 32'(m_hs));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int exp_gap[5];
  int exp_len;
  int ticks[$];
  int n_play;
  bit found;

  task automatic run_play(output int n, output bit ok);
    ok = 1'b0;
    n = 0;
    ticks.delete();
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (mole_tick) ticks.push_back(i);
      if (state == 2'd3) begin
        n = i; ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    if (SPEED) begin
      exp_gap = '{20, 16, 12, 8, 8};
      exp_len = 64;
    end else begin
      exp_gap = '{20, 20, 20, 20, 20};
      exp_len = 100;
    end
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_game_rst", 32'(game_rst), 32'd1);
    chk("rst_idle", 32'(idle_step), 32'd0);
    chk("rst_high", 32'(high_score), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    repeat (3) @(negedge clk);
    chk("idle_t3", 32'(idle_step), 32'd1);
    repeat (24) @(negedge clk);
    chk("idle_t27", 32'(idle_step), 32'd9);
    repeat (3) @(negedge clk);
    chk("idle_wrap", 32'(idle_step), 32'd0);

    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    chk("cd_enter", 32'(cd_digit), 32'd3);
    repeat (9) @(negedge clk);
    chk("cd3_last", 32'(cd_digit), 32'd3);
    @(negedge clk);
    chk("cd2", 32'(cd_digit), 32'd2);
    repeat (10) @(negedge clk);
    chk("cd1", 32'(cd_digit), 32'd1);
    repeat (10) @(negedge clk);
    chk("play_state", 32'(state), 32'd2);
    chk("play_game_rst", 32'(game_rst), 32'd0);

    score_in = 24'h001234;
    run_play(n_play, found);
    chk("game1_end", 32'(found), 32'd1);
    chk("game1_len", 32'(n_play), 32'(exp_len));
    chk("game1_ticks", 32'(ticks.size()), 32'd5);
    for (int k = 0; k < 5 && k < ticks.size(); k++)
      chk("tick_gap", 32'(ticks[k] - ((k == 0) ? 0 : ticks[k-1])),
          32'(exp_gap[k]));
    chk("game1_rounds", 32'(round_num), 32'd5);

    start_btn = 1'b1;
    @(negedge clk);
    chk("go_first_ignored", 32'(state), 32'd3);
    chk("final1", 32'(final_score), 32'h001234);
    chk("high1", 32'(high_score), 32'h001234);
    chk("go_game_rst", 32'(game_rst), 32'd1);
    start_btn = 1'b0;
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    chk("restart", 32'(state), 32'd1);

    score_in = 24'h000100;
    repeat (30) @(negedge clk);
    chk("play2_state", 32'(state), 32'd2);
    run_play(n_play, found);
    chk("game2_end", 32'(found), 32'd1);
    @(negedge clk);
    chk("final2", 32'(final_score), 32'h000100);
    chk("high2", 32'(high_score), 32'h001234);
    repeat (48) @(negedge clk);
    chk("go_t49", 32'(state), 32'd3);
    @(negedge clk);
    chk("go_timeout", 32'(state), 32'd0);
    chk("go_idle0", 32'(idle_step), 32'd0);

    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    repeat (30) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (round_num == 8'd2) begin found = 1'b1; break; end
    end
    chk("reach_rn2", 32'(found), 32'd1);
    rst = 1'b1;
    start_btn = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_game_rst", 32'(game_rst), 32'd1);
    chk("mid_rst_rc", 32'(round_count), 32'd0);
    chk("mid_rst_high", 32'(high_score), 32'd0);
    rst = 1'b0;
    start_btn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_btn_ignored", 32'(state), 32'd0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
Top-level game sequencer for the whack-a-mole datapath. Steps the game through four phases: attract, countdown, play and game-over. In play, generates the mole-change tick and the in-round cycle count used for scoring, shortening the round period as the game progresses. Holds the mole/score block in reset outside play, latches the final score, and tracks a high score.

Parameters:
INIT_PERIOD, 100000000, cycles in round 0 (must be <= 100000000 so the scoring term stays non-negative)
MIN_PERIOD, 25000000, floor on the round period
PERIOD_STEP, 2500000, period decrement applied after each round
ROUNDS, 30, mole ticks per game (1..255)
IDLE_PERIOD, 5000000, cycles per attract-animation step
CD_PERIOD, 100000000, cycles per countdown digit
GAMEOVER_CYCLES, 500000000, game-over display time before returning to attract

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_btn  in  1  start request, already synchronised level; rising edge detected internally
score_in  in  24  running score from the mole block
game_rst  out  1  reset/idle-animation enable to the mole block
mole_tick  out  1  one-cycle pulse: load new random mole pattern
round_count  out  28  cycles elapsed in the current round
idle_step  out  4  attract-animation index, 0..9
cd_digit  out  2  countdown digit 3/2/1; 0 when not counting down
round_num  out  8  rounds completed this game
state  out  2  0=ATTRACT 1=COUNTDOWN 2=PLAY 3=GAMEOVER
final_score  out  24  score latched at end of last game
high_score  out  24  best final_score since rst

Behaviour:
- rst (any state, any time): state=ATTRACT, game_rst=1, mole_tick=0, round_count=0, idle_step=0, cd_digit=0, round_num=0, final_score=0, high_score=0, period=INIT_PERIOD, edge detector primed with start_btn=0. Reset mid-game abandons the game with no score latch.
- All outputs are registered. Each transition takes effect on the clock edge after its condition is seen.
- ATTRACT:
  - game_rst=1.
  - Divider counts 0..IDLE_PERIOD-1. At terminal count, idle_step advances and wraps 9->0.
  - start_btn rising edge -> COUNTDOWN. Entering COUNTDOWN loads cd_digit=3 and clears the divider.
- COUNTDOWN:
  - game_rst=1.
  - cd_digit holds for CD_PERIOD cycles each: 3, then 2, then 1.
  - After the 1 expires -> PLAY, with cd_digit=0, round_count=0, round_num=0, period=INIT_PERIOD.
  - start_btn edges are ignored.
- PLAY:
  - game_rst=0.
  - round_count increments every cycle.
  - When round_count==period-1:
    - mole_tick=1 for exactly that next cycle.
    - round_count<=0, round_num<=round_num+1.
    - period<=max(period-PERIOD_STEP, MIN_PERIOD), saturating with no underflow.
  - On the tick that makes round_num==ROUNDS -> GAMEOVER. That final tick is still emitted.
  - Play length = sum of the ROUNDS periods.
  - start_btn edges are ignored.
- GAMEOVER:
  - First cycle: game_rst stays 0 and final_score<=score_in. If score_in>high_score, high_score<=score_in.
  - From the second cycle: game_rst=1 and mole_tick=0.
  - Timer counts GAMEOVER_CYCLES -> ATTRACT with idle_step=0.
  - A start_btn rising edge after the first cycle -> COUNTDOWN immediately. If it coincides with timer expiry, COUNTDOWN wins.
- round_count never exceeds period-1, and is therefore always < 100000000.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined: period decrements per round as specified.
- Undefined: period is fixed at INIT_PERIOD for the whole game. MIN_PERIOD and PERIOD_STEP are unused, and play length = ROUNDS*INIT_PERIOD.

Test Plan:
All scenarios use INIT_PERIOD=20, MIN_PERIOD=8, PERIOD_STEP=4, ROUNDS=5, IDLE_PERIOD=3, CD_PERIOD=10, GAMEOVER_CYCLES=50.
- Release rst, no start: idle_step steps 0,1,..,9,0 every 3 cycles; game_rst=1; state=0.
- start_btn pulse in ATTRACT: cd_digit reads 3,2,1 for 10 cycles each; then state=2 and game_rst=0.
- Full game (MOLE_SPEEDUP_EN defined): mole_tick gaps are 20,16,12,8,8 cycles; round_num ends at 5; state=3 after 64 play cycles.
- Same game with the macro undefined: five ticks 20 apart; 100 play cycles.
- score_in=0x001234 at game end, then second game with score_in=0x000100: final_score=0x000100, high_score=0x001234. After 50 idle cycles, state returns to 0.
- rst asserted at round_num=2 in PLAY: next cycle state=0, game_rst=1, round_count=0, high_score=0. A start_btn edge the same cycle as rst is ignored.
